dec_key_entry: RTL and testbench

- Keyed decimal-entry decoder: accepts single-cycle key events (digits, sign, clear, backspace, enter) and builds a signed decimal number.
- On enter, converts the number to an 8-bit two's-complement value, range-checks it, and presents it to the datapath.
- This is the input-direction counterpart of the signed-decimal 7-segment display path.
- Key events come from debounced buttons through the falling-edge detector. The live entry outputs feed the decimal display for echo.

---
 rtl/dec_key_entry.sv | 149 ++++++++++++++
 tb/tb_dec_key_entry.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/dec_key_entry.sv
// Keyed decimal-entry decoder: collects digit/sign/edit keys into a signed
// decimal entry and, on ENT, publishes it as a range-checked two's-complement value.
module dec_key_entry #(
    parameter int WIDTH      = 8,
    parameter int MAX_DIGITS = 3,
    parameter int MAG_W      = $clog2(10**MAX_DIGITS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    output logic [WIDTH-1:0] value,
    output logic             value_valid,
    output logic             err,
    output logic [MAG_W-1:0] entry_mag,
    output logic             entry_neg,
    output logic [1:0]       entry_digits,
    output logic             entry_ovf
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENTRY  = 2'd1,
        ST_REPORT = 2'd2
    } state_e;

    localparam logic [3:0] KEY_NEG  = 4'hA;
    localparam logic [3:0] KEY_CLR  = 4'hB;
    localparam logic [3:0] KEY_ENT  = 4'hC;
    localparam logic [3:0] KEY_BKSP = 4'hD;

    localparam int CMP_W = ((MAG_W > WIDTH) ? MAG_W : WIDTH) + 1;
    localparam logic [CMP_W-1:0] NEG_LIM = CMP_W'(1) << (WIDTH - 1);
    localparam logic [CMP_W-1:0] POS_LIM = NEG_LIM - CMP_W'(1);
    localparam logic [1:0]       DIG_MAX = 2'(MAX_DIGITS);

    state_e           state_q, state_d;
    logic             report_err_q, report_err_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic [MAG_W-1:0] entry_mag_q, entry_mag_d;
    logic             entry_neg_q, entry_neg_d;
    logic [1:0]       entry_digits_q, entry_digits_d;
    logic             entry_ovf_s;
    logic             pulse_ok_s;
    logic             pulse_err_s;
    logic [CMP_W-1:0] mag_ext_s;
    logic [WIDTH-1:0] mag_trunc_s;

    // Range check of the live entry against the signed result range.
    always_comb begin
        mag_ext_s = CMP_W'(entry_mag_q);
        if (entry_neg_q) begin
            entry_ovf_s = (mag_ext_s > NEG_LIM);
        end else begin
            entry_ovf_s = (mag_ext_s > POS_LIM);
        end
    end

    // Key decode and next-state computation for entry, result and FSM.
    always_comb begin
        entry_mag_d    = entry_mag_q;
        entry_neg_d    = entry_neg_q;
        entry_digits_d = entry_digits_q;
        value_d        = value_q;
        pulse_ok_s     = 1'b0;
        pulse_err_s    = 1'b0;
        mag_trunc_s    = WIDTH'(entry_mag_q);

        if (key_valid) begin
            case (key_code)
                KEY_NEG: begin
                    entry_neg_d = ~entry_neg_q;
                end
                KEY_CLR: begin
                    entry_mag_d    = '0;
                    entry_neg_d    = 1'b0;
                    entry_digits_d = 2'd0;
                end
                KEY_ENT: begin
                    if ((entry_digits_q == 2'd0) || entry_ovf_s) begin
                        pulse_err_s = 1'b1;
                    end else begin
                        // Truncation makes -2^(WIDTH-1) wrap to the correct pattern.
                        value_d        = entry_neg_q ? (WIDTH'(0) - mag_trunc_s) : mag_trunc_s;
                        pulse_ok_s     = 1'b1;
                        entry_mag_d    = '0;
                        entry_neg_d    = 1'b0;
                        entry_digits_d = 2'd0;
                    end
                end
                KEY_BKSP: begin
                    if (entry_digits_q != 2'd0) begin
                        entry_mag_d    = entry_mag_q / MAG_W'(10);
                        entry_digits_d = entry_digits_q - 2'd1;
                    end else begin
                        entry_digits_d = entry_digits_q;
                    end
                end
                default: begin
                    if ((key_code <= 4'd9) && (entry_digits_q < DIG_MAX)) begin
                        entry_mag_d    = MAG_W'(entry_mag_q * MAG_W'(10) + MAG_W'(key_code));
                        entry_digits_d = entry_digits_q + 2'd1;
                    end else begin
                        entry_digits_d = entry_digits_q;
                    end
                end
            endcase
        end else begin
            entry_mag_d = entry_mag_q;
        end

        report_err_d = pulse_err_s;
        if (pulse_ok_s || pulse_err_s) begin
            state_d = ST_REPORT;
        end else if ((entry_digits_d == 2'd0) && !entry_neg_d) begin
            state_d = ST_IDLE;
        end else begin
            state_d = ST_ENTRY;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            report_err_q   <= 1'b0;
            value_q        <= '0;
            entry_mag_q    <= '0;
            entry_neg_q    <= 1'b0;
            entry_digits_q <= 2'd0;
        end else begin
            state_q        <= state_d;
            report_err_q   <= report_err_d;
            value_q        <= value_d;
            entry_mag_q    <= entry_mag_d;
            entry_neg_q    <= entry_neg_d;
            entry_digits_q <= entry_digits_d;
        end
    end

    assign value        = value_q;
    assign value_valid  = (state_q == ST_REPORT) && !report_err_q;
    assign err          = (state_q == ST_REPORT) && report_err_q;
    assign entry_mag    = entry_mag_q;
    assign entry_neg    = entry_neg_q;
    assign entry_digits = entry_digits_q;
    assign entry_ovf    = entry_ovf_s;

endmodule

// File: tb/tb_dec_key_entry.sv
// Bench for dec_key_entry: directed key sequences plus random keys, checked
// after every clock against an integer-arithmetic model of the entry rules.
module tb_dec_key_entry;

    logic       clk;
    logic       reset;
    logic       key_valid;
    logic [3:0] key_code;
    logic [7:0] value;
    logic       value_valid;
    logic       err;
    logic [9:0] entry_mag;
    logic       entry_neg;
    logic [1:0] entry_digits;
    logic       entry_ovf;

    int errors = 0;
    int checks = 0;

    int m_mag, m_neg, m_dig, m_val, m_vv, m_err;

    dec_key_entry dut (
        .clk          (clk),
        .reset        (reset),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .value        (value),
        .value_valid  (value_valid),
        .err          (err),
        .entry_mag    (entry_mag),
        .entry_neg    (entry_neg),
        .entry_digits (entry_digits),
        .entry_ovf    (entry_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_ovf(input int mag, input int neg);
        int v;
        v = (neg != 0) ? -mag : mag;
        return ((v < -128) || (v > 127)) ? 1 : 0;
    endfunction

    task automatic model_update(input logic rst, input logic kv, input logic [3:0] code);
        int c;
        int v;
        c = int'(code);
        m_vv = 0;
        m_err = 0;
        if (rst) begin
            m_mag = 0; m_neg = 0; m_dig = 0; m_val = 0;
        end else if (kv) begin
            if (c <= 9) begin
                if (m_dig < 3) begin
                    m_mag = m_mag * 10 + c;
                    m_dig = m_dig + 1;
                end
            end else if (c == 10) begin
                m_neg = (m_neg != 0) ? 0 : 1;
            end else if (c == 11) begin
                m_mag = 0; m_neg = 0; m_dig = 0;
            end else if (c == 12) begin
                if ((m_dig == 0) || (model_ovf(m_mag, m_neg) != 0)) begin
                    m_err = 1;
                end else begin
                    v = (m_neg != 0) ? -m_mag : m_mag;
                    m_val = v & 255;
                    m_vv = 1;
                    m_mag = 0; m_neg = 0; m_dig = 0;
                end
            end else if (c == 13) begin
                if (m_dig > 0) begin
                    m_mag = m_mag / 10;
                    m_dig = m_dig - 1;
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic kv, input logic [3:0] code);
        @(negedge clk);
        reset     = rst;
        key_valid = kv;
        key_code  = code;
        @(posedge clk);
        #1;
        model_update(rst, kv, code);
        check("value",        32'(value),        32'(m_val));
        check("value_valid",  32'(value_valid),  32'(m_vv));
        check("err",          32'(err),          32'(m_err));
        check("entry_mag",    32'(entry_mag),    32'(m_mag));
        check("entry_neg",    32'(entry_neg),    32'(m_neg));
        check("entry_digits", 32'(entry_digits), 32'(m_dig));
        check("entry_ovf",    32'(entry_ovf),    32'(model_ovf(m_mag, m_neg)));
        check("pulse_excl",   32'(value_valid & err), 32'(0));
    endtask

    task automatic key(input logic [3:0] code);
        step(1'b0, 1'b1, code);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'h0);
    endtask

    initial begin
        reset = 1'b1; key_valid = 1'b0; key_code = 4'h0;
        m_mag = 0; m_neg = 0; m_dig = 0; m_val = 0; m_vv = 0; m_err = 0;
        step(1'b1, 1'b0, 4'h0);
        step(1'b1, 1'b0, 4'h0);

        // 127 is the largest positive value
        key(4'd1); key(4'd2); key(4'd7); key(4'hC); idle();
        // -128 accepted, then +128 rejected and recovered by backspace
        key(4'hA); key(4'd1); key(4'd2); key(4'd8); key(4'hC); idle();
        key(4'd1); key(4'd2); key(4'd8); key(4'hC); idle();
        key(4'hD); key(4'hC); idle();
        // fourth digit ignored, then clear
        key(4'd9); key(4'd9); key(4'd9); key(4'd9); key(4'hB); idle();
        // ENT with no digits, and negative zero
        key(4'hC); idle(); key(4'hA); key(4'd0); key(4'hC); idle();
        // held key counts per cycle, then reset beats a pending ENT
        key(4'd5); key(4'd5); key(4'd5); idle();
        step(1'b1, 1'b1, 4'hC); idle();
        // double sign toggle, empty backspace, ignored codes
        key(4'hA); key(4'hA); key(4'd4); key(4'd2); key(4'hC);
        key(4'hD); key(4'hE); key(4'hF); idle();
        // back-to-back ENT keys landing in the report cycle
        key(4'd3); key(4'hC); key(4'hC); key(4'hA); key(4'hC); idle();

        for (int i = 0; i < 600; i++) begin
            logic [3:0] c;
            logic       kv;
            kv = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) begin
                c = 4'(($urandom_range(0, 1) == 0) ? 4'hC : 4'hD);
            end else begin
                c = 4'($urandom_range(0, 15));
            end
            step(($urandom_range(0, 99) == 0), kv, c);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
